// File: rtl/ctrl_msg_merger_pkg.sv
// Shared constants for the core-to-scheduler control message merger.
// Holds default widths and the control message type encoding.
package ctrl_msg_merger_pkg;

  localparam int CORE_COUNT_DEF    = 16;
  localparam int DATA_WIDTH_DEF    = 64;
  localparam int CTRL_MSG_TYPE_LSB = 56;
  localparam int CTRL_MSG_TYPE_W   = 8;

  typedef enum logic [CTRL_MSG_TYPE_W-1:0] {
    MSG_SLOT_FREE   = 8'd0,
    MSG_LOOPBACK    = 8'd1,
    MSG_SLOT_CONFIG = 8'd4
  } ctrl_msg_type_e;

  // Extracts the raw type field; left as plain bits because unknown encodings are legal traffic.
  function automatic logic [CTRL_MSG_TYPE_W-1:0] ctrl_msg_type(
    input logic [DATA_WIDTH_DEF-1:0] beat
  );
    return beat[CTRL_MSG_TYPE_LSB +: CTRL_MSG_TYPE_W];
  endfunction

endpackage

// File: rtl/ctrl_msg_merger_if.sv
// Stream bundle between the per-core control inputs, the merger and the scheduler.
// The merger uses the slave view; the producer/consumer side uses master.
interface ctrl_msg_merger_if
  import ctrl_msg_merger_pkg::*;
#(
  parameter int CORE_COUNT    = CORE_COUNT_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int CORE_ID_WIDTH = $clog2(CORE_COUNT)
);

  logic [CORE_COUNT*DATA_WIDTH-1:0] s_axis_tdata;
  logic [CORE_COUNT-1:0]            s_axis_tvalid;
  logic [CORE_COUNT-1:0]            s_axis_tready;
  logic [CORE_COUNT-1:0]            s_axis_tlast;

  logic [DATA_WIDTH-1:0]            m_axis_tdata;
  logic                             m_axis_tvalid;
  logic                             m_axis_tready;
  logic                             m_axis_tlast;
  logic [CORE_ID_WIDTH-1:0]         m_axis_tuser;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );

endinterface

// File: rtl/ctrl_msg_merger_in_buf.sv
// Two-entry per-core input FIFO. ready_o comes straight from the count
// register so the core-facing tready has no combinational input path.
module ctrl_in_buf
  import ctrl_msg_merger_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic                  head_vld_o
);

  logic [1:0][DATA_WIDTH-1:0] mem_q;
  logic                       wr_ptr_q, wr_ptr_d;
  logic                       rd_ptr_q, rd_ptr_d;
  logic [1:0]                 cnt_q, cnt_d;
  logic                       do_push, do_pop;

  assign ready_o    = (cnt_q != 2'd2);
  assign head_vld_o = (cnt_q != 2'd0);
  assign head_o     = mem_q[rd_ptr_q];

  assign do_push = push_i && ready_o;
  assign do_pop  = pop_i && head_vld_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = ~wr_ptr_q;
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only observable while counted.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ctrl_msg_merger.sv
// Merges per-core single-beat control messages into one registered stream
// for the scheduler, round-robin across cores, source core index on tuser.
module ctrl_msg_merger
  import ctrl_msg_merger_pkg::*;
#(
  parameter int CORE_COUNT    = CORE_COUNT_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int CORE_ID_WIDTH = $clog2(CORE_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  ctrl_msg_merger_if.slave      bus,
  output logic [CORE_COUNT-1:0] err_no_last
);

  logic [CORE_COUNT-1:0]                 push, pop, buf_rdy, head_vld;
  logic [CORE_COUNT-1:0][DATA_WIDTH-1:0] head_data;

  logic [CORE_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [CORE_ID_WIDTH-1:0] winner;
  logic                     any_req, out_ld, grant;

  logic                     m_vld_q, m_vld_d;
  logic [DATA_WIDTH-1:0]    m_data_q, m_data_d;
  logic [CORE_ID_WIDTH-1:0] m_user_q, m_user_d;
  logic [CORE_COUNT-1:0]    err_q, err_d;

  for (genvar i = 0; i < CORE_COUNT; i++) begin : g_buf
    ctrl_in_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push[i]),
      .data_i     (bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH]),
      .ready_o    (buf_rdy[i]),
      .pop_i      (pop[i]),
      .head_o     (head_data[i]),
      .head_vld_o (head_vld[i])
    );
  end

  assign bus.s_axis_tready = buf_rdy & {CORE_COUNT{~rst}};
  assign push              = bus.s_axis_tvalid & bus.s_axis_tready;

  // Walk offsets from farthest to nearest so the nearest requester after the pointer wins.
  always_comb begin
    int idx;
    idx     = 0;
    winner  = '0;
    any_req = 1'b0;
    for (int off = CORE_COUNT; off >= 1; off--) begin
      idx = (int'(rr_ptr_q) + off) % CORE_COUNT;
      if (head_vld[idx]) begin
        winner  = CORE_ID_WIDTH'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign out_ld = !m_vld_q || bus.m_axis_tready;
  assign grant  = any_req && out_ld;

  always_comb begin
    m_vld_d  = m_vld_q;
    m_data_d = m_data_q;
    m_user_d = m_user_q;
    rr_ptr_d = rr_ptr_q;
    pop      = '0;
    if (grant) begin
      pop[winner] = 1'b1;
      m_vld_d     = 1'b1;
      m_data_d    = head_data[winner];
      m_user_d    = winner;
      rr_ptr_d    = winner;
    end else if (bus.m_axis_tready) begin
      m_vld_d = 1'b0;
    end
  end

  // Flag is raised on acceptance, independent of when the beat is forwarded.
  assign err_d = err_q | (push & ~bus.s_axis_tlast);

  always_ff @(posedge clk) begin
    if (rst) begin
      m_vld_q  <= 1'b0;
      m_data_q <= '0;
      m_user_q <= '0;
      rr_ptr_q <= CORE_ID_WIDTH'(CORE_COUNT - 1);
      err_q    <= '0;
    end else begin
      m_vld_q  <= m_vld_d;
      m_data_q <= m_data_d;
      m_user_q <= m_user_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  assign bus.m_axis_tvalid = m_vld_q;
  assign bus.m_axis_tdata  = m_data_q;
  assign bus.m_axis_tuser  = m_user_q;
  assign bus.m_axis_tlast  = 1'b1;
  assign err_no_last       = err_q;

endmodule

// File: tb/tb_ctrl_msg_merger.sv
// Directed bench for ctrl_msg_merger: single beat, all-core burst,
// backpressure, two-core fairness, mid-traffic reset and missing tlast.
module tb_ctrl_msg_merger;

  localparam int NC = 16;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NC-1:0] err;
  int            cyc = 0;
  int            n_chk = 0;
  int            n_err = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [3:0]    u;
    logic          l;
    int            c;
  } beat_t;
  beat_t q[$];

  ctrl_msg_merger_if #(.CORE_COUNT(NC), .DATA_WIDTH(DW)) bus ();

  ctrl_msg_merger #(.CORE_COUNT(NC), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .err_no_last (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    beat_t b;
    if (!rst && bus.m_axis_tvalid && bus.m_axis_tready) begin
      b.d = bus.m_axis_tdata;
      b.u = bus.m_axis_tuser;
      b.l = bus.m_axis_tlast;
      b.c = cyc;
      q.push_back(b);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tlast  = '1;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    q.delete();
  endtask

  task automatic send1(input int core, input logic [63:0] d, input logic last);
    bus.s_axis_tdata[core*DW +: DW] = d;
    bus.s_axis_tvalid[core]         = 1'b1;
    bus.s_axis_tlast[core]          = last;
    tick();
    bus.s_axis_tvalid[core]         = 1'b0;
    bus.s_axis_tlast[core]          = 1'b1;
  endtask

  initial begin
    int c0, n0, n3;
    logic [31:0] seq0, seq3;
    logic a0, a3;

    idle_in();
    bus.m_axis_tready = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
    chk("rst_tdata",  bus.m_axis_tdata,       64'd0);
    chk("rst_tuser",  64'(bus.m_axis_tuser),  64'd0);
    chk("rst_err",    64'(err),               64'd0);
    chk("rst_tready", 64'(bus.s_axis_tready), 64'hffff);

    // Single message from core 5: visible two cycles after drive
    tick();
    q.delete();
    c0 = cyc;
    send1(5, 64'h0000_0000_0003_0000, 1'b1);
    repeat (6) tick();
    chk("single_count", 64'(q.size()), 64'd1);
    if (q.size() >= 1) begin
      chk("single_data",  q[0].d,        64'h0000_0000_0003_0000);
      chk("single_user",  64'(q[0].u),   64'd5);
      chk("single_last",  64'(q[0].l),   64'd1);
      chk("single_lat",   64'(q[0].c),   64'(c0 + 2));
    end

    // All 16 cores at once: in-order tuser, back-to-back
    do_reset();
    for (int i = 0; i < NC; i++)
      bus.s_axis_tdata[i*DW +: DW] = 64'h0400_0000_0000_0000 | 64'(i);
    bus.s_axis_tvalid = '1;
    tick();
    idle_in();
    repeat (25) tick();
    chk("all_count", 64'(q.size()), 64'd16);
    if (q.size() == 16) begin
      for (int i = 0; i < NC; i++) begin
        chk("all_user", 64'(q[i].u), 64'(i));
        chk("all_data", q[i].d, 64'h0400_0000_0000_0000 | 64'(i));
        chk("all_gap",  64'(q[i].c), 64'(q[0].c + i));
      end
    end

    // Backpressure on core 2
    do_reset();
    bus.m_axis_tready = 1'b0;
    send1(2, 64'hA, 1'b1);
    send1(2, 64'hB, 1'b1);
    send1(2, 64'hC, 1'b1);
    @(negedge clk);
    chk("bp_tready_low", 64'(bus.s_axis_tready[2]), 64'd0);
    chk("bp_out_valid",  64'(bus.m_axis_tvalid),    64'd1);
    chk("bp_out_head",   bus.m_axis_tdata,          64'hA);
    repeat (17) tick();
    chk("bp_stable",     bus.m_axis_tdata,          64'hA);
    bus.m_axis_tready = 1'b1;
    repeat (6) tick();
    chk("bp_count", 64'(q.size()), 64'd3);
    if (q.size() == 3) begin
      chk("bp_beat0", q[0].d, 64'hA);
      chk("bp_beat1", q[1].d, 64'hB);
      chk("bp_beat2", q[2].d, 64'hC);
    end
    chk("bp_tready_back", 64'(bus.s_axis_tready[2]), 64'd1);

    // Fairness between cores 0 and 3, per-core sequence numbers in data
    do_reset();
    seq0 = 0;
    seq3 = 0;
    for (int k = 0; k < 120; k++) begin
      bus.s_axis_tdata[0*DW +: DW] = {32'h0, seq0};
      bus.s_axis_tdata[3*DW +: DW] = {32'h3, seq3};
      bus.s_axis_tvalid[0] = 1'b1;
      bus.s_axis_tvalid[3] = 1'b1;
      @(negedge clk);
      a0 = bus.s_axis_tready[0];
      a3 = bus.s_axis_tready[3];
      tick();
      if (a0) seq0++;
      if (a3) seq3++;
    end
    idle_in();
    repeat (8) tick();
    chk("fair_enough", 64'(q.size() >= 100), 64'd1);
    n0 = 0;
    n3 = 0;
    if (q.size() >= 100) begin
      for (int k = 0; k < 100; k++) begin
        if (k % 2 == 0) begin
          chk("fair_user", 64'(q[k].u), 64'd0);
          chk("fair_data", q[k].d, {32'h0, 32'(n0)});
          n0++;
        end else begin
          chk("fair_user", 64'(q[k].u), 64'd3);
          chk("fair_data", q[k].d, {32'h3, 32'(n3)});
          n3++;
        end
      end
    end
    chk("fair_n0", 64'(n0), 64'd50);
    chk("fair_n3", 64'(n3), 64'd50);

    // Reset while buffers and output hold traffic
    do_reset();
    bus.m_axis_tready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      bus.s_axis_tdata[1*DW +: DW]  = 64'h11;
      bus.s_axis_tdata[4*DW +: DW]  = 64'h44;
      bus.s_axis_tdata[9*DW +: DW]  = 64'h99;
      bus.s_axis_tdata[12*DW +: DW] = 64'hCC;
      bus.s_axis_tvalid = 16'h1212;
      bus.s_axis_tlast  = 16'hefff;
      tick();
    end
    idle_in();
    @(negedge clk);
    chk("mid_pre_valid", 64'(bus.m_axis_tvalid), 64'd1);
    chk("mid_pre_err",   64'(err),               64'h1000);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_valid",  64'(bus.m_axis_tvalid), 64'd0);
    chk("mid_tready", 64'(bus.s_axis_tready), 64'hffff);
    chk("mid_err",    64'(err),               64'd0);
    q.delete();
    bus.m_axis_tready = 1'b1;
    tick();
    bus.s_axis_tdata[6*DW +: DW]  = 64'h66;
    bus.s_axis_tdata[10*DW +: DW] = 64'hAA;
    bus.s_axis_tvalid = 16'h0440;
    tick();
    idle_in();
    repeat (6) tick();
    chk("mid_count", 64'(q.size()), 64'd2);
    if (q.size() == 2) begin
      chk("mid_first_user",  64'(q[0].u), 64'd6);
      chk("mid_second_user", 64'(q[1].u), 64'd10);
    end

    // Missing tlast on core 7
    do_reset();
    send1(7, 64'h0100_0000_0000_0077, 1'b0);
    @(negedge clk);
    chk("nolast_set", 64'(err), 64'h0080);
    repeat (10) tick();
    chk("nolast_sticky", 64'(err), 64'h0080);
    chk("nolast_count", 64'(q.size()), 64'd1);
    if (q.size() == 1) begin
      chk("nolast_user", 64'(q[0].u), 64'd7);
      chk("nolast_data", q[0].d, 64'h0100_0000_0000_0077);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
